// File: rtl/riscv_config_pkg.sv
// Core-wide configuration constants shared by the pipeline and memory-side blocks.
package riscv_config_pkg;

    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/riscv_core_pkg.sv
// Core-wide types shared by the pipeline and memory-side blocks.
package riscv_core_pkg;

    typedef enum logic [2:0] {
        DMEM_IDLE,
        DMEM_REQ,
        DMEM_RSP,
        DMEM_DONE,
        DMEM_DRAIN
    } dmem_state_e;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one outstanding valid/ready bus transaction per
// M-stage load/store, with pipeline stall, flush draining and response timeout.
module dmem_access_ctrl
    import riscv_core_pkg::*;
    import riscv_config_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_valid_i,
    input  logic [31:0] core_req_addr_i,
    input  logic        core_req_write_i,
    input  logic [2:0]  core_req_size_i,
    input  logic [31:0] core_req_data_i,
    input  logic [3:0]  core_req_strb_i,
    input  logic        core_req_kill_i,
    input  logic        advance_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        core_rsp_valid_o,
    output logic [31:0] core_rsp_data_o,
    output logic        core_rsp_error_o,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic [31:0] bus_req_addr_o,
    output logic        bus_req_write_o,
    output logic [2:0]  bus_req_size_o,
    output logic [31:0] bus_req_data_o,
    output logic [3:0]  bus_req_strb_o,
    input  logic        bus_rsp_valid_i,
    output logic        bus_rsp_ready_o,
    input  logic [31:0] bus_rsp_data_i,
    input  logic        bus_rsp_error_i,
    output logic        bus_timeout_o
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    dmem_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_error_q, rsp_error_d;
    logic        flushed_q, flushed_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic        timeout_q, timeout_d;
    logic        tmo_expired;

    // The counter holds the number of completed RSP/DRAIN cycles, so the wait
    // lasts exactly TIMEOUT_CYCLES cycles before the expiry takes effect.
    assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        data_d      = data_q;
        strb_d      = strb_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        flushed_d   = flushed_q;
        timeout_d   = timeout_q;
        tmo_d       = (tmo_q != TMO_MAX) ? tmo_q + TMO_W'(1) : tmo_q;

        case (state_q)
            DMEM_IDLE: begin
                if (core_req_valid_i && !flush_i) begin
                    if (core_req_kill_i) begin
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b0;
                        state_d     = DMEM_DONE;
                    end else begin
                        addr_d    = core_req_addr_i;
                        write_d   = core_req_write_i;
                        size_d    = core_req_size_i;
                        data_d    = core_req_data_i;
                        strb_d    = core_req_strb_i;
                        flushed_d = 1'b0;
                        state_d   = DMEM_REQ;
                    end
                end
            end
            DMEM_REQ: begin
                if (flush_i) flushed_d = 1'b1;
                if (bus_req_ready_i) begin
                    tmo_d   = '0;
                    state_d = (flushed_q || flush_i) ? DMEM_DRAIN : DMEM_RSP;
                end
            end
            DMEM_RSP: begin
                if (bus_rsp_valid_i && flush_i) begin
                    state_d = DMEM_IDLE;
                end else if (bus_rsp_valid_i) begin
                    rsp_data_d  = bus_rsp_data_i;
                    rsp_error_d = bus_rsp_error_i;
                    state_d     = DMEM_DONE;
                end else if (flush_i) begin
                    tmo_d   = '0;
                    state_d = DMEM_DRAIN;
                end else if (tmo_expired) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                if (advance_i || flush_i) state_d = DMEM_IDLE;
            end
            DMEM_DRAIN: begin
                if (bus_rsp_valid_i) begin
                    state_d = DMEM_IDLE;
                end else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    state_d   = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst_i) begin
            state_q     <= DMEM_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            flushed_q   <= 1'b0;
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            flushed_q   <= flushed_d;
            tmo_q       <= tmo_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_o          = core_req_valid_i && (state_q != DMEM_DONE);
    assign core_rsp_valid_o = (state_q == DMEM_DONE);
    assign core_rsp_data_o  = rsp_data_q;
    assign core_rsp_error_o = rsp_error_q;
    assign bus_req_valid_o  = (state_q == DMEM_REQ);
    assign bus_req_addr_o   = addr_q;
    assign bus_req_write_o  = write_q;
    assign bus_req_size_o   = size_q;
    assign bus_req_data_o   = data_q;
    assign bus_req_strb_o   = strb_q;
    assign bus_rsp_ready_o  = (state_q == DMEM_RSP) || (state_q == DMEM_DRAIN);
    assign bus_timeout_o    = timeout_q;

endmodule
